phoneme_sequencer: RTL and testbench

//  Upstream stage of the flash audio player FSM. Queues phoneme codes written by the

---
 rtl/phoneme_sequencer.sv | 167 ++++++++++++++++
 tb/tb_phoneme_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phoneme_sequencer.sv
// rtl/phoneme_sequencer.sv - phoneme code FIFO and segment address lookup for the flash audio player
module phoneme_sequencer #(
    parameter int DEPTH   = 16,
    parameter int CODE_W  = 6,
    parameter int ADDR_W  = 24,
    parameter int ROM_LAT = 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   code_valid_i,
    input  logic [CODE_W-1:0]      code_in_i,
    output logic                   code_ready_o,
    input  logic                   flush_i,
    input  logic                   pico_flag_i,
    output logic                   pico_done_o,
    output logic [ADDR_W-1:0]      start_address_o,
    output logic [ADDR_W-1:0]      end_address_o,
    output logic                   silent_o,
    output logic                   rom_rd_o,
    output logic [CODE_W-1:0]      rom_addr_o,
    input  logic [2*ADDR_W-1:0]    rom_data_i,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic [7:0]             underruns_o,
    output logic [7:0]             bad_entries_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_ROM_WAIT,
        S_LATCH,
        S_SILENCE,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic               rom_rd_q;
    logic [CODE_W-1:0]  rom_addr_q;
    logic               pico_done_q;
    logic [ADDR_W-1:0]  start_q, end_q;
    logic               silent_q;
    logic [7:0]         underruns_q, bad_q;

    logic               full, empty, pop, push;
    logic               latch_en, silence_en;
    logic [ADDR_W-1:0]  rom_start, rom_end;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    // The head is popped on the same edge the request is accepted, so rom_addr
    // is already valid during the single rom_rd cycle.
    assign pop        = (state_q == S_IDLE) && pico_flag_i && !empty;
    // A full FIFO may still take a push on the cycle its head leaves.
    assign push       = code_valid_i && (!full || pop) && !flush_i;
    assign silence_en = (state_q == S_IDLE) && pico_flag_i && empty;
    assign latch_en   = (state_q == S_ROM_WAIT) && (lat_cnt_q == LAT_W'(ROM_LAT - 1));
    assign rom_start  = rom_data_i[ADDR_W-1:0];
    assign rom_end    = rom_data_i[2*ADDR_W-1:ADDR_W];

    // Code storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= code_in_i;
        end
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the request/lookup/handshake sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (pico_flag_i) state_d = empty ? S_SILENCE : S_POP;
            S_POP:      state_d = S_ROM_WAIT;
            S_ROM_WAIT: if (latch_en) state_d = S_LATCH;
            S_LATCH:    state_d = S_DONE;
            S_SILENCE:  state_d = S_DONE;
            S_DONE:     state_d = S_WAIT_LOW;
            S_WAIT_LOW: if (!pico_flag_i) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Registered outputs. Segment fields are loaded on entry to LATCH/SILENCE so
    // they are settled for a full cycle before pico_done rises in DONE.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            lat_cnt_q   <= '0;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            pico_done_q <= 1'b0;
            start_q     <= '0;
            end_q       <= '0;
            silent_q    <= 1'b1;
            underruns_q <= '0;
            bad_q       <= '0;
        end else begin
            lat_cnt_q   <= (state_q == S_ROM_WAIT) ? lat_cnt_q + 1'b1 : '0;
            rom_rd_q    <= pop;
            pico_done_q <= (state_d == S_DONE);
            if (pop) begin
                rom_addr_q <= mem_q[rd_ptr_q];
            end
            if (latch_en) begin
                if (rom_end < rom_start) begin
                    silent_q <= 1'b1;
                    if (bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
                end else begin
                    start_q  <= rom_start;
                    end_q    <= rom_end;
                    silent_q <= 1'b0;
                end
            end
            if (silence_en) begin
                silent_q <= 1'b1;
                if (underruns_q != 8'hFF) underruns_q <= underruns_q + 8'd1;
            end
        end
    end

    assign code_ready_o    = !full;
    assign fifo_count_o    = count_q;
    assign rom_rd_o        = rom_rd_q;
    assign rom_addr_o      = rom_addr_q;
    assign pico_done_o     = pico_done_q;
    assign start_address_o = start_q;
    assign end_address_o   = end_q;
    assign silent_o        = silent_q;
    assign underruns_o     = underruns_q;
    assign bad_entries_o   = bad_q;
endmodule

// File: tb/tb_phoneme_sequencer.sv
// tb/tb_phoneme_sequencer.sv - self-checking bench for phoneme_sequencer
module tb_phoneme_sequencer;
    localparam int DEPTH   = 16;
    localparam int ROM_LAT = 1;

    logic        clk;
    logic        rst;
    logic        code_valid;
    logic [5:0]  code_in;
    logic        code_ready;
    logic        flush;
    logic        pico_flag;
    logic        pico_done;
    logic [23:0] start_a, end_a;
    logic        silent;
    logic        rom_rd;
    logic [5:0]  rom_addr;
    logic [47:0] rom_data;
    logic [4:0]  fifo_count;
    logic [7:0]  underruns, bad_entries;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    phoneme_sequencer #(.DEPTH(DEPTH), .CODE_W(6), .ADDR_W(24), .ROM_LAT(ROM_LAT)) dut (
        .clock_i(clk), .reset_i(rst),
        .code_valid_i(code_valid), .code_in_i(code_in), .code_ready_o(code_ready),
        .flush_i(flush), .pico_flag_i(pico_flag), .pico_done_o(pico_done),
        .start_address_o(start_a), .end_address_o(end_a), .silent_o(silent),
        .rom_rd_o(rom_rd), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .fifo_count_o(fifo_count), .underruns_o(underruns), .bad_entries_o(bad_entries)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data is only valid exactly ROM_LAT cycles after rom_rd.
    logic [47:0] rom_mem [64];
    logic [47:0] pipe_d  [ROM_LAT];
    logic        pipe_v  [ROM_LAT];
    always @(posedge clk) begin
        pipe_v[0] <= rom_rd;
        pipe_d[0] <= rom_mem[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign rom_data = pipe_v[ROM_LAT-1] ? pipe_d[ROM_LAT-1] : 48'hA5A5A5_5A5A5A;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a request accepted at edge 0 pops (or inserts silence),
    // segment fields appear after edge ROM_LAT+1 (silence: edge 0), pico_done is
    // high for one cycle after, then the flag must be seen low before a new request.
    logic [5:0]  m_q [$];
    bit          m_busy, m_wl, m_sreq;
    int          m_k, m_under, m_bad;
    logic [5:0]  m_code;
    logic [23:0] m_start, m_end;
    bit          m_sil;

    always @(posedge clk or posedge rst) begin : model
        bit          busy, wl, sreq, popping;
        int          k, un, bd, sz;
        logic [5:0]  code;
        logic [23:0] st, en;
        bit          sil;
        logic [47:0] ent;
        if (rst) begin
            m_q.delete();
            m_busy <= 0; m_wl <= 0; m_sreq <= 0; m_k <= 0;
            m_under <= 0; m_bad <= 0; m_code <= '0;
            m_start <= '0; m_end <= '0; m_sil <= 1;
        end else begin
            busy = m_busy; wl = m_wl; sreq = m_sreq; k = m_k;
            un = m_under; bd = m_bad; code = m_code;
            st = m_start; en = m_end; sil = m_sil;
            popping = 0;
            sz = m_q.size();
            if (wl) begin
                if (!pico_flag) wl = 0;
            end else if (!busy) begin
                if (pico_flag) begin
                    busy = 1; k = 0;
                    if (sz > 0) begin
                        sreq = 0; code = m_q[0]; popping = 1;
                    end else begin
                        sreq = 1; sil = 1;
                        if (un < 255) un++;
                    end
                end
            end else begin
                k++;
                if (!sreq && k == ROM_LAT + 1) begin
                    ent = rom_mem[code];
                    if (ent[47:24] < ent[23:0]) begin
                        sil = 1;
                        if (bd < 255) bd++;
                    end else begin
                        st = ent[23:0]; en = ent[47:24]; sil = 0;
                    end
                end
                if (k == (sreq ? 2 : ROM_LAT + 3)) begin
                    busy = 0; wl = 1;
                end
            end
            if (popping) void'(m_q.pop_front());
            if (flush) m_q.delete();
            else if (code_valid && (sz < DEPTH || popping)) m_q.push_back(code_in);
            m_busy <= busy; m_wl <= wl; m_sreq <= sreq; m_k <= k;
            m_under <= un; m_bad <= bd; m_code <= code;
            m_start <= st; m_end <= en; m_sil <= sil;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("code_ready", code_ready, (m_q.size() < DEPTH));
            chk("fifo_count", fifo_count, m_q.size());
            chk("pico_done", pico_done, m_busy && (m_sreq ? (m_k == 1) : (m_k == ROM_LAT + 2)));
            chk("rom_rd", rom_rd, m_busy && !m_sreq && (m_k == 0));
            chk("rom_addr", rom_addr, m_code);
            chk("start_address", start_a, m_start);
            chk("end_address", end_a, m_end);
            chk("silent", silent, m_sil);
            chk("underruns", underruns, m_under);
            chk("bad_entries", bad_entries, m_bad);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [5:0] c);
        code_in = c; code_valid = 1;
        @(negedge clk);
        code_valid = 0;
    endtask

    task automatic req(input bit drop, output int lat, output logic [5:0] addr);
        pico_flag = 1; lat = 0; addr = '0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rom_rd) addr = rom_addr;
            if (pico_done) break;
        end
        chk("req_done_seen", pico_done, 1);
        if (drop) pico_flag = 0;
    endtask

    int         lat, n;
    logic [5:0] addr;

    initial begin
        for (int c = 0; c < 64; c++) begin
            rom_mem[c] = {24'(32'h1080 + c * 256), 24'(32'h1000 + c * 256)};
        end
        rom_mem[5] = {24'h000800, 24'h000400};
        rom_mem[9] = {24'h000100, 24'h000200};
        rst = 1; code_valid = 0; code_in = '0; flush = 0; pico_flag = 0;
        tick(3);
        cmp_en = 1;
        tick(1);
        chk("rst_silent", silent, 1);
        chk("rst_code_ready", code_ready, 1);
        chk("rst_start", start_a, 0);
        rst = 0;
        tick(1);

        // empty FIFO -> silence in 2 cycles
        req(1, lat, addr);
        chk("empty_latency", lat, 2);
        chk("empty_silent", silent, 1);
        chk("empty_start", start_a, 0);
        chk("empty_end", end_a, 0);
        chk("empty_underruns", underruns, 1);
        tick(3);

        // queued code 5
        push(6'd5);
        req(1, lat, addr);
        chk("code5_latency", lat, ROM_LAT + 3);
        chk("code5_rom_addr", addr, 5);
        chk("code5_start", start_a, 24'h000400);
        chk("code5_end", end_a, 24'h000800);
        chk("code5_silent", silent, 0);
        tick(3);

        // held pico_flag -> one pulse, one pop
        push(6'd7);
        push(6'd8);
        chk("two_pushed", fifo_count, 2);
        req(0, lat, addr);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (pico_done) n++;
        end
        chk("hold_extra_done", n, 0);
        chk("hold_one_pop", fifo_count, 1);
        chk("hold_addr", addr, 7);
        pico_flag = 0;
        tick(3);

        // flush wins over a same-cycle push
        flush = 1; code_valid = 1; code_in = 6'd20;
        @(negedge clk);
        flush = 0; code_valid = 0;
        chk("flush_empty", fifo_count, 0);

        // fill past full, then drain in order
        for (int i = 0; i < 17; i++) push(6'(10 + i));
        chk("full_ready", code_ready, 0);
        chk("full_count", fifo_count, 16);
        for (int i = 0; i < 16; i++) begin
            req(1, lat, addr);
            chk("order_addr", addr, 10 + i);
            chk("order_latency", lat, ROM_LAT + 3);
            tick(2);
        end
        chk("drained_count", fifo_count, 0);
        chk("last_start", start_a, 24'h002900);

        // end < start entry
        push(6'd9);
        req(1, lat, addr);
        chk("bad_silent", silent, 1);
        chk("bad_start_held", start_a, 24'h002900);
        chk("bad_end_held", end_a, 24'h002980);
        chk("bad_count", bad_entries, 1);
        tick(3);

        // async reset during ROM_WAIT
        push(6'd3);
        pico_flag = 1;
        n = 0;
        while (n < 10 && !rom_rd) begin
            @(negedge clk);
            n++;
        end
        chk("rst_rom_rd_seen", rom_rd, 1);
        @(posedge clk);
        #2;
        rst = 1; pico_flag = 0;
        @(negedge clk);
        chk("arst_done", pico_done, 0);
        chk("arst_rom_rd", rom_rd, 0);
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_silent", silent, 1);
        chk("arst_start", start_a, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_bad", bad_entries, 0);
        chk("arst_under", underruns, 0);
        tick(2);
        rst = 0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (pico_done) n++;
        end
        chk("arst_no_done", n, 0);

        req(1, lat, addr);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_under", underruns, 1);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
